// File: rtl/adsr_env_poly_pkg.sv
// adsr_env_poly_pkg: envelope state encoding and saturating step helper
package adsr_env_poly_pkg;
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } env_state_t;

    // Moves a by b toward lim without passing it; 32-bit math keeps AMP_W+1 headroom.
    function automatic logic [31:0] sat_step(input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] lim, input logic up);
        return up ? ((a + b >= lim) ? lim : a + b) : ((a <= lim + b) ? lim : a - b);
    endfunction
endpackage

// File: rtl/adsr_env_poly_env_voice.sv
// env_voice: one ADSR envelope FSM with its amplitude register
module env_voice
    import adsr_env_poly_pkg::*;
#(
    parameter int AMP_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             gate,
    input  logic [AMP_W-1:0] attack,
    input  logic [AMP_W-1:0] decay,
    input  logic [AMP_W-1:0] sus_eff,
    input  logic [AMP_W-1:0] rel,
    input  logic [AMP_W-1:0] max_amplitude,
    output logic [AMP_W-1:0] amplitude,
    output logic             active
);
    env_state_t state, state_n;
    logic [AMP_W-1:0] amp_n;
    logic gate_q, rise;
    logic [31:0] att_v, dec_v, rel_v;
    assign rise = gate & ~gate_q;
    // A zero rate means "jump straight to the endpoint": a step of 2^AMP_W always reaches it.
    assign att_v = sat_step(32'(amplitude), attack == '0 ? 32'(max_amplitude) : 32'(attack),
                            32'(max_amplitude), 1'b1);
    assign dec_v = sat_step(32'(amplitude), decay == '0 ? 32'd1 << AMP_W : 32'(decay),
                            32'(sus_eff), 1'b0);
    assign rel_v = sat_step(32'(amplitude), rel == '0 ? 32'd1 << AMP_W : 32'(rel), '0, 1'b0);
    always_comb begin
        state_n = state;
        amp_n   = amplitude;
        if (rise)
            state_n = ATTACK;
        else if (!gate && (state == ATTACK || state == DECAY || state == SUSTAIN))
            state_n = RELEASE;
        else if (tick)
            case (state)
                IDLE:    amp_n = '0;
                ATTACK: begin
                    amp_n   = AMP_W'(att_v);
                    state_n = att_v == 32'(max_amplitude) ? DECAY : ATTACK;
                end
                DECAY: begin
                    amp_n   = AMP_W'(dec_v);
                    state_n = dec_v == 32'(sus_eff) ? SUSTAIN : DECAY;
                end
                SUSTAIN: amp_n = sus_eff;
                RELEASE: begin
                    amp_n   = AMP_W'(rel_v);
                    state_n = rel_v == '0 ? IDLE : RELEASE;
                end
                default: begin
                    amp_n   = '0;
                    state_n = IDLE;
                end
            endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            amplitude <= '0;
            gate_q    <= 1'b0;
            active    <= 1'b0;
        end else begin
            state     <= state_n;
            amplitude <= amp_n;
            gate_q    <= gate;
            active    <= state_n != IDLE;
        end
    end
endmodule

// File: rtl/adsr_env_poly.sv
// adsr_env_poly: multi-voice ADSR envelope generator sharing one rate tick
module adsr_env_poly
    import adsr_env_poly_pkg::*;
#(
    parameter int VOICES   = 4,
    parameter int AMP_W    = 8,
    parameter int TICK_DIV = 50000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [VOICES-1:0]       gate,
    input  logic [AMP_W-1:0]        attack,
    input  logic [AMP_W-1:0]        decay,
    input  logic [AMP_W-1:0]        sustain,
    input  logic [AMP_W-1:0]        rel,
    input  logic [AMP_W-1:0]        max_amplitude,
    output logic [VOICES*AMP_W-1:0] amplitude,
    output logic [VOICES-1:0]       active
);
    localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    logic [CW-1:0] cnt;
    logic tick;
    logic [AMP_W-1:0] sus_eff;
    assign tick    = cnt == CW'(TICK_DIV - 1);
    assign sus_eff = sustain < max_amplitude ? sustain : max_amplitude;
    always_ff @(posedge clk) begin
        if (reset || tick)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end
    for (genvar g = 0; g < VOICES; g++) begin : g_voice
        env_voice #(.AMP_W(AMP_W)) u_voice (
            .clk          (clk),
            .reset        (reset),
            .tick         (tick),
            .gate         (gate[g]),
            .attack       (attack),
            .decay        (decay),
            .sus_eff      (sus_eff),
            .rel          (rel),
            .max_amplitude(max_amplitude),
            .amplitude    (amplitude[g*AMP_W +: AMP_W]),
            .active       (active[g])
        );
    end
endmodule
